// File: rtl/shift_alu_pkg.sv
// Shared constants, opcode encodings and scheduler state type for the
// shift ALU scheduler slice.
package shift_alu_pkg;

    localparam int REGISTER_WIDTH = 32;

    localparam logic [2:0] SHLEFTLOG = 3'b000;
    localparam logic [2:0] SHLEFTART = 3'b001;
    localparam logic [2:0] SHRGHTLOG = 3'b010;
    localparam logic [2:0] SHRGHTART = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    // Any opcode with the top bit set has no ALU meaning.
    function automatic logic op_illegal(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/shift_alu_sched_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past last_grant
// and wraps, so the most recent winner has the lowest priority.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    // First valid requester found walking forward from last_grant+1.
    always_comb begin
        int  cand_s;
        logic sel_s;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s        = (int'(last_grant) + i) % NUM_REQ;
            sel_s         = !any && valid[cand_s];
            grant[cand_s] = sel_s;
            idx           = sel_s ? ID_W'(cand_s) : idx;
            any           = any | sel_s;
        end
    end

endmodule

// File: rtl/shift_alu_sched.sv
// Round-robin scheduler sharing one registered shift ALU among NUM_REQ
// requesters; illegal opcodes are answered directly without the ALU.
module shift_alu_sched
    import shift_alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][2:0]            req_op,
    input  logic [NUM_REQ-1:0][4:0]            req_shift,
    input  logic [NUM_REQ-1:0][REGISTER_WIDTH-1:0] req_data,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [ID_W-1:0]                    rsp_id,
    output logic [REGISTER_WIDTH:0]            rsp_data,
    output logic                               rsp_err,
    output logic                               alu_enable,
    output logic [2:0]                         alu_shift_operation,
    output logic [4:0]                         alu_shift,
    output logic [REGISTER_WIDTH-1:0]          alu_in,
    input  logic [REGISTER_WIDTH:0]            alu_out,
    output logic [15:0]                        done_count
);

    sched_state_t        state_r;
    sched_state_t        next_state_s;
    logic [ID_W-1:0]     last_grant_r;
    logic [ID_W-1:0]     win_idx_s;
    logic [NUM_REQ-1:0]  win_grant_s;
    logic                win_any_s;
    logic                accept_s;
    logic                rsp_hs_s;
    logic [2:0]          sel_op_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .valid      (req_valid),
        .last_grant (last_grant_r),
        .grant      (win_grant_s),
        .idx        (win_idx_s),
        .any        (win_any_s)
    );

    assign sel_op_s = req_op[win_idx_s];
    assign accept_s = |(req_valid & req_ready);
    assign rsp_hs_s = rsp_valid && rsp_ready;

    // Ready follows the picker only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if ((state_r == IDLE) && !reset && win_any_s) begin
            req_ready = win_grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state selection.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = op_illegal(sel_op_s) ? RESP : ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE:   next_state_s = WAIT;
            WAIT:    next_state_s = RESP;
            RESP: begin
                if (rsp_hs_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand latching, ALU drive, response capture and completion count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_r        <= ID_W'(NUM_REQ - 1);
            alu_enable          <= 1'b0;
            alu_shift_operation <= 3'd0;
            alu_shift           <= 5'd0;
            alu_in              <= '0;
            rsp_valid           <= 1'b0;
            rsp_id              <= '0;
            rsp_data            <= '0;
            rsp_err             <= 1'b0;
            done_count          <= 16'd0;
        end else begin
            alu_enable <= (next_state_s == ISSUE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        last_grant_r <= win_idx_s;
                        rsp_id       <= win_idx_s;
                        if (op_illegal(sel_op_s)) begin
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_valid <= 1'b1;
                        end else begin
                            rsp_err             <= 1'b0;
                            alu_shift_operation <= sel_op_s;
                            alu_shift           <= req_shift[win_idx_s];
                            alu_in              <= req_data[win_idx_s];
                        end
                    end
                end
                WAIT: begin
                    rsp_data  <= alu_out;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_hs_s) begin
                        rsp_valid  <= 1'b0;
                        done_count <= done_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_alu_sched.sv
// Directed scoreboard bench for shift_alu_sched with a behavioural
// registered shift ALU attached to the alu_* ports.
module tb_shift_alu_sched;
    import shift_alu_pkg::*;

    logic            clock;
    logic            reset;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [3:0][2:0] req_op;
    logic [3:0][4:0] req_shift;
    logic [3:0][31:0] req_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [32:0]     rsp_data;
    logic            rsp_err;
    logic            alu_enable;
    logic [2:0]      alu_shift_operation;
    logic [4:0]      alu_shift;
    logic [31:0]     alu_in;
    logic [32:0]     alu_out;
    logic [15:0]     done_count;

    typedef struct packed {
        logic [1:0]  id;
        logic [32:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_done = 0;

    shift_alu_sched #(.NUM_REQ(4)) dut (
        .clock               (clock),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_op              (req_op),
        .req_shift           (req_shift),
        .req_data            (req_data),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_id              (rsp_id),
        .rsp_data            (rsp_data),
        .rsp_err             (rsp_err),
        .alu_enable          (alu_enable),
        .alu_shift_operation (alu_shift_operation),
        .alu_shift           (alu_shift),
        .alu_in              (alu_in),
        .alu_out             (alu_out),
        .done_count          (done_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [32:0] alu_f(input logic [2:0] op, input logic [4:0] sh,
                                          input logic [31:0] d);
        case (op)
            SHLEFTLOG, SHLEFTART: alu_f = {1'b0, d} << sh;
            SHRGHTLOG:            alu_f = {1'b0, d >> sh};
            SHRGHTART:            alu_f = {1'b0, 32'($signed(d) >>> sh)};
            default:              alu_f = 33'd0;
        endcase
    endfunction

    // Behavioural ALU: result registered one cycle after enable.
    initial alu_out = 33'd0;
    always @(posedge clock) begin
        if (alu_enable) alu_out <= alu_f(alu_shift_operation, alu_shift, alu_in);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
            chk({tag, "_id"},    64'(rsp_id),    64'(e.id));
            chk({tag, "_data"},  64'(rsp_data),  64'(e.data));
            chk({tag, "_err"},   64'(rsp_err),   64'(e.err));
        end
    endtask

    // Single request from requester r with rsp_ready held high.
    task automatic do_req(input string tag, input int r, input logic [2:0] op,
                          input logic [4:0] sh, input logic [31:0] d,
                          input logic [32:0] exp_data, input int exp_lat);
        int lat;
        int en_cnt;
        logic [3:0] oh;
        oh = 4'(1 << r);
        sb.push_back('{id: 2'(r), data: exp_data, err: op[2]});
        @(negedge clock);
        req_valid    = oh;
        req_op[r]    = op;
        req_shift[r] = sh;
        req_data[r]  = d;
        #1;
        chk({tag, "_ready"}, 64'(req_ready), 64'(oh));
        @(posedge clock); #1;
        req_valid = 4'd0;
        lat = 1;
        en_cnt = 0;
        while (lat < 20) begin
            en_cnt += int'(alu_enable);
            if (rsp_valid) break;
            @(posedge clock); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_alu_en_cycles"}, 64'(en_cnt), op[2] ? 64'd0 : 64'd1);
        check_rsp(tag);
        @(posedge clock); #1;
        exp_done++;
        chk({tag, "_done"}, 64'(done_count), 64'(exp_done));
        chk({tag, "_rsp_dropped"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        int lat;
        int hi_cnt;
        int r;
        logic [2:0]  op;
        logic [4:0]  sh;
        logic [31:0] d;

        reset     = 1'b1;
        req_valid = 4'hF;
        req_op    = '0;
        req_shift = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        #12;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id",    64'(rsp_id),    64'd0);
        chk("rst_rsp_data",  64'(rsp_data),  64'd0);
        chk("rst_rsp_err",   64'(rsp_err),   64'd0);
        chk("rst_alu_en",    64'(alu_enable), 64'd0);
        chk("rst_alu_ops",   64'({alu_shift_operation, alu_shift, alu_in}), 64'd0);
        chk("rst_done",      64'(done_count), 64'd0);
        req_valid = 4'd0;
        @(negedge clock);
        reset = 1'b0;

        do_req("single",  0, SHLEFTLOG, 5'd4, 32'h0000_00F1, 33'h0_0000_0F10, 3);
        do_req("sra",     2, SHRGHTART, 5'd8, 32'h8000_0000, 33'h0_FF80_0000, 3);
        do_req("sla",     3, SHLEFTART, 5'd1, 32'h8000_0001, 33'h1_0000_0002, 3);
        do_req("illegal", 1, 3'b101,    5'd7, 32'h1234_5678, 33'h0,           1);

        for (int k = 0; k < 6; k++) begin
            r  = int'($urandom_range(0, 3));
            op = 3'($urandom_range(0, 3));
            sh = 5'($urandom_range(0, 31));
            d  = $urandom;
            do_req("rand", r, op, sh, d, alu_f(op, sh, d), 3);
        end
        do_req("illegal2", 3, 3'b111, 5'd0, 32'hFFFF_FFFF, 33'h0, 1);

        // Backpressure: hold rsp_ready low for 5 cycles in RESP.
        rsp_ready = 1'b0;
        sb.push_back('{id: 2'd1, data: alu_f(SHRGHTLOG, 5'd3, 32'hF0F0_F0F0), err: 1'b0});
        @(negedge clock);
        req_valid    = 4'b0010;
        req_op[1]    = SHRGHTLOG;
        req_shift[1] = 5'd3;
        req_data[1]  = 32'hF0F0_F0F0;
        @(posedge clock); #1;
        req_valid = 4'b1101;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("bp_latency", 64'(lat), 64'd3);
        repeat (5) begin
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_id",    64'(rsp_id),    64'd1);
            chk("bp_data",  64'(rsp_data),  64'(alu_f(SHRGHTLOG, 5'd3, 32'hF0F0_F0F0)));
            chk("bp_ready", 64'(req_ready), 64'd0);
            @(posedge clock); #1;
        end
        chk("bp_done_held", 64'(done_count), 64'(exp_done));
        req_valid = 4'd0;
        rsp_ready = 1'b1;
        check_rsp("bp_release");
        @(posedge clock); #1;
        exp_done++;
        chk("bp_single_hs", 64'(rsp_valid), 64'd0);
        chk("bp_done", 64'(done_count), 64'(exp_done));
        @(posedge clock); #1;
        chk("bp_done_after", 64'(done_count), 64'(exp_done));

        // Async reset asserted in WAIT drops the transaction.
        @(negedge clock);
        req_valid    = 4'b0100;
        req_op[2]    = SHLEFTLOG;
        req_shift[2] = 5'd2;
        req_data[2]  = 32'h0F0F_0F0F;
        @(posedge clock); #1;
        req_valid = 4'd0;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk("wrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("wrst_rsp",       64'({rsp_id, rsp_data, rsp_err}), 64'd0);
        chk("wrst_alu",       64'({alu_enable, alu_shift_operation, alu_shift, alu_in}), 64'd0);
        chk("wrst_done",      64'(done_count), 64'd0);
        chk("wrst_req_ready", 64'(req_ready), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        exp_done = 0;
        hi_cnt = 0;
        repeat (4) begin
            @(posedge clock); #1;
            hi_cnt += int'(rsp_valid);
        end
        chk("wrst_no_rsp", 64'(hi_cnt), 64'd0);

        // Fairness: all requesters valid continuously for 8 operations.
        for (int i = 0; i < 4; i++) begin
            req_op[i]    = 3'(i);
            req_shift[i] = 5'(i * 3 + 1);
            req_data[i]  = 32'hA5A5_0000 + 32'(i * 32'h0101_0011);
        end
        for (int n = 0; n < 8; n++) begin
            sb.push_back('{id: 2'(n % 4),
                           data: alu_f(req_op[n % 4], req_shift[n % 4], req_data[n % 4]),
                           err: 1'b0});
        end
        @(negedge clock);
        req_valid = 4'hF;
        #1;
        chk("fair_first_grant", 64'(req_ready), 64'd1);
        for (int n = 0; n < 8; n++) begin
            lat = 0;
            while (!rsp_valid && lat < 20) begin
                @(posedge clock); #1;
                lat++;
            end
            chk("fair_wait", 64'(rsp_valid), 64'd1);
            check_rsp("fair");
            @(posedge clock); #1;
            exp_done++;
        end
        req_valid = 4'd0;
        chk("fair_done", 64'(done_count), 64'd8);
        chk("fair_done_model", 64'(done_count), 64'(exp_done));
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_alu_sched.md
# shift_alu_sched

Round-robin scheduler that shares one `SHIFT_ALU` instance among `NUM_REQ` requesters. It accepts one shift request at a time over valid/ready, drives the ALU for one enable cycle, captures the 33-bit registered result, and returns it on a single shared response channel tagged with the requester index. It sits between the shift-issuing clients and the ALU. It also screens out illegal opcodes without using the ALU.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `ID_W`, $clog2(NUM_REQ), width of requester tag
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `req_valid` in NUM_REQ: per-requester request valid
- `req_ready` out NUM_REQ: per-requester accept; one-hot or zero
- `req_op` in NUM_REQ×3: shift operation per requester
- `req_shift` in NUM_REQ×5: shift amount per requester
- `req_data` in NUM_REQ×32: operand per requester
- `rsp_valid` out 1: response valid
- `rsp_ready` in 1: response consumer ready
- `rsp_id` out ID_W: index of the originating requester
- `rsp_data` out 33: {carry, result} from ALU; 0 on error
- `rsp_err` out 1: illegal opcode (op[2]=1)
- `alu_enable` out 1: to ALU `enable`
- `alu_shift_operation` out 3, `alu_shift` out 5, `alu_in` out 32: to ALU operands
- `alu_out` in 33: from ALU `aluout` (registered in ALU, 1-cycle latency)
- `done_count` out 16: completed responses, wraps at 0xFFFF→0

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: the rr picker selects one valid requester. Priority starts at `last_grant+1` and wraps modulo NUM_REQ. `req_ready[winner]`=1 combinationally; no other ready is high.
  - Handshake: latch op/shift/data/id and set `last_grant`=winner.
  - If op[2]=0 → ISSUE.
  - If op[2]=1 → RESP with `rsp_err`=1, `rsp_data`=0. The ALU is not enabled.
- ISSUE: `alu_enable`=1 for exactly this cycle, with latched operands on `alu_*` (registered outputs). → WAIT.
- WAIT: `alu_out` holds the result. Capture it into the `rsp_data` register. → RESP.
- RESP: `rsp_valid`=1 with stable id/data/err. On `rsp_valid && rsp_ready`: `done_count`++ and → IDLE. Otherwise hold.
- `req_ready` is 0 in all states except IDLE. No new request is accepted while a response is pending.
- `alu_enable` is 0 in every state except ISSUE. `alu_*` operands hold their last value otherwise.

## Timing
- Reset values, applied asynchronously:
  - state=IDLE, `last_grant`=NUM_REQ-1 (requester 0 has first priority)
  - `req_ready`=0 while reset is asserted
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0
  - `alu_enable`=0, `alu_shift_operation`=0, `alu_shift`=0, `alu_in`=0
  - `done_count`=0
- Legal op, accept at cycle T: `alu_enable` high in T+1, capture at end of T+2, `rsp_valid` first high in T+3. With `rsp_ready`=1, the next accept is at T+4. Minimum 4 cycles per op.
- Illegal op, accept at T: `rsp_valid` in T+1. Minimum 2 cycles per op.
- A requester dropping `req_valid` in IDLE before the handshake loses nothing. The picker re-evaluates every IDLE cycle.
- All requesters valid continuously: grants rotate 0,1,2,3,0,… with no starvation.
- Reset mid-operation (ISSUE/WAIT/RESP): the transaction is dropped, no response is produced, and `done_count` is not incremented.
- `done_count` increments only on a response handshake, including error responses.

## Structure
- Package `shift_alu_pkg`:
  - `REGISTER_WIDTH`=32
  - opcode constants SHLEFTLOG=000, SHLEFTART=001, SHRGHTLOG=010, SHRGHTART=011
  - `sched_state_t` enum {IDLE, ISSUE, WAIT, RESP}
- Sub-module `rr_arbiter`: combinational round-robin picker. Inputs are the valid vector and `last_grant`; outputs are a one-hot grant and the encoded index. The top level owns the `last_grant` register.

## Test plan
- Single request: requester 0, SHLEFTLOG, shift=4, data=0x0000_00F1 → `rsp_valid` at T+3, `rsp_id`=0, `rsp_data`=0x0_0000_0F10, `rsp_err`=0.
- Arithmetic ops:
  - requester 2, SHRGHTART, shift=8, data=0x8000_0000 → `rsp_data`=0x0_FF80_0000.
  - SHLEFTART, shift=1, data=0x8000_0001 → `rsp_data`=0x1_0000_0002.
- Fairness: all 4 requesters valid continuously for 8 ops → `rsp_id` sequence 0,1,2,3,0,1,2,3, and `done_count`=8.
- Illegal op: requester 1, op=3'b101 → `rsp_valid` at T+1, `rsp_err`=1, `rsp_data`=0, `alu_enable` never high.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP → `rsp_*` stable, all `req_ready`=0, and a single handshake when released.
- Async reset asserted in WAIT → outputs go to reset values immediately, and the next request is granted to requester 0.
